// File: rtl/boolean_identity_sweeper.sv
// boolean_identity_sweeper
//   Walks an exhaustive N-bit input vector through two combinational
//   expression datapaths (LHS and RHS), one vector per cycle. It compares
//   their outputs on every cycle and reports:
//     - the number of mismatching vectors,
//     - the lowest vector that mismatched,
//     - an overall pass flag once the sweep completes.
//
// Ports
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   start            begin a sweep (sampled only in IDLE)
//   abort            cancel a running sweep (sampled only in SWEEP)
//   lhs_f, rhs_f     datapath outputs, combinational from vec
//   vec              registered vector driven to both datapaths
//   busy             high while sweeping
//   done             one-cycle pulse on sweep completion
//   pass             1 iff the completed sweep saw zero mismatches
//   mismatch_count   number of mismatching vectors (N+1 bits, holds 2^N)
//   fail_valid       at least one mismatch seen this sweep
//   first_fail       lowest mismatching vector (valid with fail_valid)
//
// State | meaning
// IDLE  | waiting for start; results of the last sweep stay readable
// SWEEP | presenting vectors 0..2^N-1 and comparing one per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module boolean_identity_sweeper #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         lhs_f,
  input  logic         rhs_f,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   mismatch_count,
  output logic         fail_valid,
  output logic [N-1:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] VEC_LAST = '1;

  state_t       state, state_nxt;
  logic [N-1:0] vec_nxt;
  logic         busy_nxt;
  logic         done_nxt;
  logic         pass_nxt;
  logic [N:0]   count_nxt;
  logic         fail_valid_nxt;
  logic [N-1:0] first_fail_nxt;
  logic         miss;

  assign miss = lhs_f ^ rhs_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      first_fail     <= '0;
    end else begin
      state          <= state_nxt;
      vec            <= vec_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      mismatch_count <= count_nxt;
      fail_valid     <= fail_valid_nxt;
      first_fail     <= first_fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    count_nxt      = mismatch_count;
    fail_valid_nxt = fail_valid;
    first_fail_nxt = first_fail;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = SWEEP;
          vec_nxt        = '0;
          busy_nxt       = 1'b1;
          pass_nxt       = 1'b0;
          count_nxt      = '0;
          fail_valid_nxt = 1'b0;
          first_fail_nxt = '0;
        end
      end

      SWEEP: begin
        if (abort) begin
          // The compare of the aborted cycle is dropped; partial counts stay.
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          vec_nxt   = '0;
          pass_nxt  = 1'b0;
        end else begin
          if (miss) begin
            count_nxt = mismatch_count + 1'b1;
            // Vectors rise monotonically, so the first miss is the lowest one.
            if (!fail_valid) begin
              fail_valid_nxt = 1'b1;
              first_fail_nxt = vec;
            end
          end
          if (vec == VEC_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            vec_nxt   = '0;
            // Uses the count including this last compare.
            pass_nxt  = (count_nxt == '0);
          end else begin
            vec_nxt = vec + 1'b1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/boolean_identity_sweeper.md
# boolean_identity_sweeper

Self-checking sequencer for the Boolean-algebra verification exercises. It drives an exhaustive input vector onto two combinational datapaths, one implementing the LHS expression and one the RHS, and compares their outputs every cycle. It counts mismatches and reports pass/fail with the first failing vector. It sits between the lab top level, which supplies start/abort, and the pair of expression modules under proof, e.g. double negation `(A')' = A`.

## Interface
- `N`, default 3, number of expression inputs; legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancel a sweep in progress; sampled only in SWEEP.
- `lhs_f`  in  1  LHS datapath output; combinational function of `vec`.
- `rhs_f`  in  1  RHS datapath output; combinational function of `vec`.
- `vec`  out  N  registered input vector driven to both datapaths.
- `busy`  out  1  high while in SWEEP.
- `done`  out  1  one-cycle pulse when a full sweep completes.
- `pass`  out  1  valid from `done` onward: 1 iff zero mismatches over all 2^N vectors.
- `mismatch_count`  out  N+1  number of mismatching vectors (max 2^N, no saturation needed).
- `fail_valid`  out  1  at least one mismatch seen this sweep.
- `first_fail`  out  N  lowest vector that mismatched; meaningful only when `fail_valid`=1.

## Operation
- FSM states: IDLE, SWEEP, DONE.
- Reset (asynchronous, any state): state=IDLE; `vec`, `busy`, `done`, `pass`, `mismatch_count`, `fail_valid`, `first_fail` all 0.
- IDLE, `start`=1 at an edge: go to SWEEP, `vec`=0, `busy`=1, clear `mismatch_count`, `fail_valid`, `first_fail`, `pass`.
- IDLE, `start`=0: hold state and all outputs. Results from the previous sweep remain readable.
- SWEEP, at every edge (no abort): compare `lhs_f` with `rhs_f` for the current `vec`.
  - On mismatch, increment `mismatch_count`.
  - On mismatch with `fail_valid`=0, also load `first_fail`=`vec` and set `fail_valid`=1.
- SWEEP, `vec` below 2^N-1: increment `vec`.
- SWEEP, `vec`=2^N-1: go to DONE.
  - `busy`=0, `done`=1, `vec`=0.
  - `pass` = (final count, including this last compare, ==0).
- DONE: lasts exactly one cycle, then go to IDLE with `done`=0. `start` is ignored in DONE.
- SWEEP, `abort`=1: go to IDLE next edge.
  - `busy`=0, `vec`=0, `pass`=0, no `done` pulse.
  - That cycle's compare is discarded. Counters keep their partial values.
- Abort on the final vector: abort wins, so no `done`.
- `start` while `busy`=1: ignored. No restart, no effect on the counters.
- Widths: `vec` is N bits and must not wrap inside SWEEP. `mismatch_count` is N+1 bits so 2^N fits.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- The datapaths are combinational from `vec`. `lhs_f`/`rhs_f` are sampled at the edge that ends the cycle in which `vec` is presented. One vector per cycle.
- With `start` sampled at edge t:
  - `busy` rises after t.
  - `vec`=k is presented in cycle t+1+k.
  - `done` is high during cycle t+1+2^N.
  - `busy` falls when `done` rises.
- Next `start` is accepted in the first IDLE cycle after `done`, i.e. the earliest restart is 2 cycles after the last vector.
- Reset mid-SWEEP: outputs clear immediately (asynchronous) and no `done` is produced.

## Test plan
- Double negation, N=1, `lhs_f`=~~`vec[0]`, `rhs_f`=`vec[0]`; pulse `start` -> `vec` shows 0,1; `done` 3 cycles after the start edge; `pass`=1, `mismatch_count`=0, `fail_valid`=0.
- False identity, N=2, `lhs_f`=a&b, `rhs_f`=a|b -> mismatches at vec 1 and 2; `mismatch_count`=2, `first_fail`=1, `fail_valid`=1, `pass`=0.
- Last-vector-only fault, N=3, `rhs_f`=`lhs_f` except inverted at vec 7 -> `mismatch_count`=1, `first_fail`=7, `pass`=0 at `done`.
- Abort, N=3, assert `abort` while `vec`=4 -> `busy` drops next edge; no `done`; `pass`=0; `vec`=0; a later `start` runs a full clean sweep.
- Start while busy, N=2: re-pulse `start` at `vec`=1 -> sweep unaffected; exactly one `done` at the normal cycle.
- Reset mid-sweep, N=3: drop `rst_n` at `vec`=5 -> all outputs 0 immediately; after release, IDLE until the next `start`.
